// File: rtl/strhw_common_types.sv
// Types shared by the stage controller and its arithmetic responders.
package strhw_common_types;

  typedef logic [511:0] uint512;

  // Status reported by multi-cycle responders on the trigger/ready interface.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ADDER_LIMB_W_DEFAULT = 64;

endpackage

// File: rtl/strhw_limb_adder512_pkg.sv
// Constants and elaboration helpers local to the 512-bit limb adder.
package strhw_limb_adder512_pkg;

  localparam int ADDER_W = 512;

  // Limb widths the adder supports; each divides ADDER_W evenly.
  function automatic bit limb_w_legal(input int w);
    return ((w == 32) || (w == 64) || (w == 128)) && ((ADDER_W % w) == 0);
  endfunction

endpackage

// File: rtl/strhw_limb_adder512_if.sv
// Trigger/ready interface between the stage controller and the 512-bit adder.
interface strhw_limb_adder512_if;
  import strhw_common_types::*;

  // Handshake: the master pulses trg_i with a_i/b_i valid on that edge. The
  // slave accepts it only when not BUSY; ready_o drops on the accepting edge
  // and rises once result_o holds (a_i + b_i) mod 2^512, staying high until
  // the next accepted trigger. result_o is meaningful only while ready_o = 1.
  logic   trg_i;
  uint512 a_i;
  uint512 b_i;
  uint512 result_o;
  logic   ready_o;
  state_t state_o;

  modport master (
    output trg_i,
    output a_i,
    output b_i,
    input  result_o,
    input  ready_o,
    input  state_o
  );

  modport slave (
    input  trg_i,
    input  a_i,
    input  b_i,
    output result_o,
    output ready_o,
    output state_o
  );

endinterface

// File: rtl/strhw_limb_add.sv
// Combinational LIMB_W-bit full adder: one limb of the ripple chain.
module strhw_limb_add #(
  parameter int LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  logic [LIMB_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
  assign sum  = full[LIMB_W-1:0];
  assign cout = full[LIMB_W];

endmodule

// File: rtl/strhw_limb_adder512.sv
// Multi-cycle 512-bit adder: one limb per clock, carry rippled through a flop,
// so the full 512-bit carry chain never sits in a single clock period.
module strhw_limb_adder512
  import strhw_common_types::*;
  import strhw_limb_adder512_pkg::*;
#(
  parameter int LIMB_W = ADDER_LIMB_W_DEFAULT
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  strhw_limb_adder512_if.slave bus
);

  localparam int                NUM_LIMBS = ADDER_W / LIMB_W;
  localparam int                CNT_W     = $clog2(NUM_LIMBS) + 1;
  localparam logic [CNT_W-1:0]  LAST_K    = CNT_W'(NUM_LIMBS - 1);

  generate
    if (!limb_w_legal(LIMB_W)) begin : g_bad_limb_w
      $error("strhw_limb_adder512: LIMB_W must be 32, 64 or 128");
    end
  endgenerate

  state_t            state_q, state_d;
  uint512            a_sh_q, a_sh_d;
  uint512            b_sh_q, b_sh_d;
  uint512            res_q, res_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  k_q, k_d;

  logic              accept;
  logic              step;
  logic [LIMB_W-1:0] limb_sum;
  logic              limb_cout;

  // A trigger while BUSY is dropped on the floor; the operation in flight
  // always runs to completion.
  assign accept = ((state_q == CLEAR) || (state_q == DONE)) && bus.trg_i;
  assign step   = (state_q == BUSY);

  strhw_limb_add #(
    .LIMB_W (LIMB_W)
  ) u_limb_add (
    .a    (a_sh_q[LIMB_W-1:0]),
    .b    (b_sh_q[LIMB_W-1:0]),
    .cin  (carry_q),
    .sum  (limb_sum),
    .cout (limb_cout)
  );

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR, DONE: begin
        if (bus.trg_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        // The edge computing the last limb also enters DONE.
        if (k_q == LAST_K) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: operands shift right one limb per step; each new sum limb
  // enters the result at the top, so after NUM_LIMBS steps limb 0 has
  // travelled down to bit 0.
  // ---------------------------------------------------------------------
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    k_d     = k_q;
    if (accept) begin
      a_sh_d  = bus.a_i;
      b_sh_d  = bus.b_i;
      carry_d = 1'b0;
      k_d     = '0;
    end else if (step) begin
      a_sh_d  = {{LIMB_W{1'b0}}, a_sh_q[ADDER_W-1:LIMB_W]};
      b_sh_d  = {{LIMB_W{1'b0}}, b_sh_q[ADDER_W-1:LIMB_W]};
      res_d   = {limb_sum, res_q[ADDER_W-1:LIMB_W]};
      carry_d = limb_cout;
      k_d     = k_q + CNT_W'(1);
    end
  end

  // The final carry-out lands in carry_q and is never observed: mod 2^512.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      k_q     <= k_d;
    end
  end

  assign bus.result_o = res_q;
  assign bus.ready_o  = (state_q == DONE);
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_strhw_limb_adder512.sv
// Directed and random checks of strhw_limb_adder512 at LIMB_W = 64, 32, 128.
module tb_strhw_limb_adder512;
  import strhw_common_types::*;

  logic clk_i;
  logic rst_ni;

  int n_total = 0;
  int n_bad   = 0;

  logic [511:0] exp_q[$];

  strhw_limb_adder512_if if64 ();
  strhw_limb_adder512_if if32 ();
  strhw_limb_adder512_if if128 ();

  strhw_limb_adder512 #(.LIMB_W(64)) dut64 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if64)
  );

  strhw_limb_adder512 #(.LIMB_W(32)) dut32 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if32)
  );

  strhw_limb_adder512 #(.LIMB_W(128)) dut128 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if128)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i*32 +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
    end
    // Plant an all-ones limb now and then so carries travel far.
    if ($urandom_range(3, 0) == 0) begin
      r[$urandom_range(15, 0)*32 +: 32] = 32'hFFFF_FFFF;
    end
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_all(input logic [511:0] a, input logic [511:0] b, input logic trg);
    if64.a_i  = a;  if64.b_i  = b;  if64.trg_i  = trg;
    if32.a_i  = a;  if32.b_i  = b;  if32.trg_i  = trg;
    if128.a_i = a;  if128.b_i = b;  if128.trg_i = trg;
  endtask

  // One operation on all three widths; called right after a negedge.
  task automatic op(input string tag, input logic [511:0] a, input logic [511:0] b,
                    input logic [511:0] exp);
    int lat64, lat32, lat128;
    logic [511:0] e_v;
    exp_q.push_back(exp);
    drive_all(a, b, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    drive_all(a, b, 1'b0);
    chk({tag, "_busy64"}, 512'(if64.state_o), 512'(BUSY));
    chk({tag, "_rdy_lo64"}, 512'(if64.ready_o), 512'(0));
    lat64 = -1; lat32 = -1; lat128 = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (lat64  < 0 && if64.ready_o)  lat64  = e;
      if (lat32  < 0 && if32.ready_o)  lat32  = e;
      if (lat128 < 0 && if128.ready_o) lat128 = e;
      if (lat64 >= 0 && lat32 >= 0 && lat128 >= 0) break;
    end
    chk({tag, "_lat64"},  512'(lat64),  512'(8));
    chk({tag, "_lat32"},  512'(lat32),  512'(16));
    chk({tag, "_lat128"}, 512'(lat128), 512'(4));
    e_v = exp_q.pop_front();
    chk({tag, "_res64"},  if64.result_o,  e_v);
    chk({tag, "_res32"},  if32.result_o,  e_v);
    chk({tag, "_res128"}, if128.result_o, e_v);
    chk({tag, "_done64"}, 512'(if64.state_o), 512'(DONE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] all1;
    logic [511:0] ra, rb;
    logic [511:0] a_keep, b_keep;

    all1   = {512{1'b1}};
    rst_ni = 1'b0;
    drive_all('0, '0, 1'b0);
    repeat (3) @(negedge clk_i);

    chk("rst_res",   if64.result_o, 512'h0);
    chk("rst_rdy",   512'(if64.ready_o), 512'(0));
    chk("rst_state", 512'(if64.state_o), 512'(CLEAR));
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_state", 512'(if64.state_o), 512'(CLEAR));

    op("zero", 512'h0, 512'h0, 512'h0);
    op("n512", 512'h0, 512'd512, 512'h200);
    op("n1024", 512'h200, 512'd512, 512'h400);
    op("limb_carry", 512'hFFFF_FFFF_FFFF_FFFF, 512'h1, 512'h1_0000_0000_0000_0000);
    op("wrap", all1, 512'h1, 512'h0);
    op("max_max", all1, all1, {{511{1'b1}}, 1'b0});

    // Triggers during BUSY must be ignored; DUT64 only.
    a_keep = 512'h1234_5678_9ABC_DEF0;
    b_keep = 512'h1111_1111_1111_1111;
    if64.a_i = a_keep; if64.b_i = b_keep; if64.trg_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if64.trg_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("ign_rdy_e%0d", e), 512'(if64.ready_o), 512'(e == 8));
      if (e == 2 || e == 4) begin
        if64.trg_i = 1'b1;
        if64.a_i   = rnd512();
        if64.b_i   = rnd512();
      end else begin
        if64.trg_i = 1'b0;
      end
    end
    chk("ign_res", if64.result_o, 512'h2345_6789_ABCD_F001);

    // Asynchronous reset in the middle of an operation.
    ra = rnd512();
    rb = rnd512();
    if64.a_i = ra; if64.b_i = rb; if64.trg_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if64.trg_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_res",    if64.result_o, 512'h0);
    chk("arst_rdy",    512'(if64.ready_o), 512'(0));
    chk("arst_state",  512'(if64.state_o), 512'(CLEAR));
    chk("arst_res128", if128.result_o, 512'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("arst_idle", 512'(if64.state_o), 512'(CLEAR));
    chk("arst_hold", if64.result_o, 512'h0);
    ra = rnd512();
    rb = rnd512();
    op("post_rst", ra, rb, ra + rb);

    for (int i = 0; i < 1000; i++) begin
      ra = rnd512();
      rb = rnd512();
      op($sformatf("rnd%0d", i), ra, rb, ra + rb);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/strhw_limb_adder512.md
Name: strhw_limb_adder512

Overview:
- Multi-cycle responder for the 512-bit adder trigger/ready interface used by the stage controller (N += 512, N += 8*len, Sigma += M).
- Captures two 512-bit operands on a trigger pulse and adds them mod 2^512, one LIMB_W-bit limb per clock, rippling the carry through a register.
- Reports completion via ready_o and a state_t status. Keeps the 512-bit carry chain out of a single clock period.

Parameters:
- LIMB_W, 64, limb width in bits; must divide 512 (elaboration-time assertion). Legal values: 32, 64, 128.
- NUM_LIMBS, 512/LIMB_W, derived localparam, not overridable; number of compute cycles.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- trg_i  in  1  start request, sampled on rising edge; one-cycle pulse by convention
- a_i  in  512  operand A, sampled only on the edge that accepts trg_i
- b_i  in  512  operand B, sampled only on the edge that accepts trg_i
- result_o  out  512  sum (a+b) mod 2^512; valid only while ready_o=1
- ready_o  out  1  1 = result_o holds the completed sum of the last accepted operation
- state_o  out  state_t  CLEAR / BUSY / DONE status (shared enum)

Behaviour:
- Reset (rst_ni=0, asynchronous, takes effect immediately):
  - result_o=0, ready_o=0, state_o=CLEAR.
  - Internal operand shift registers, carry flop and limb counter cleared.
- States: CLEAR (idle after reset), BUSY, DONE. ready_o is 1 exactly when state is DONE; registered, no combinational path from inputs.
- Accept: in CLEAR or DONE, an edge sampling trg_i=1 does all of the following on that same edge (E0):
  - latch a_i/b_i into the operand shift registers;
  - carry=0, limb count k=0;
  - state becomes BUSY, ready_o=0.
- Handshake guarantee: ready_o falls on the edge that samples trg_i. A consumer that drops trg_i one cycle later and then polls ready_o never sees stale ready.
- BUSY step, each edge:
  - {c, s} = a_sh[LIMB_W-1:0] + b_sh[LIMB_W-1:0] + carry, in LIMB_W+1 bits.
  - result register shifts right by LIMB_W with s inserted at bits [511:512-LIMB_W].
  - a_sh and b_sh shift right by LIMB_W; carry=c; k=k+1.
- Completion: the edge that computes limb NUM_LIMBS-1 also sets state DONE and ready_o=1.
  - ready_o rises exactly NUM_LIMBS edges after E0 (8 for LIMB_W=64).
  - The final carry-out is discarded (mod 2^512 wrap). No overflow output.
- During BUSY, result_o shows the partially shifted register: its upper k limbs are new sum limbs and its lower limbs are residue from the previous result. Consumers must not sample it.
- DONE holds result_o and ready_o indefinitely until the next accepted trg_i. a_i/b_i changes in DONE have no effect.
- trg_i=1 while BUSY is ignored: no restart, no queueing, and the operation in flight completes unchanged.
- Back-to-back: trg_i sampled on the same edge that DONE is entered is not accepted, because state was BUSY before that edge. trg_i on any later edge is accepted.
- trg_i held high in DONE re-triggers the operation with the current a_i/b_i. This is legal but wastes cycles; the controller pulses it.
- Counter k is $clog2(NUM_LIMBS)+1 bits, with no wrap within an operation.
- Reset asserted mid-BUSY aborts the operation; after release the block is in CLEAR with result_o=0.

Decomposition:
- strhw_common_types:
  - reuses uint512 and state_t (CLEAR/BUSY/DONE) as they stand;
  - adds localparam ADDER_LIMB_W_DEFAULT=64.
- One sub-module, strhw_limb_add: parameterised LIMB_W combinational full adder (a, b, cin -> sum, cout), instantiated once.
- All sequencing, shifting and state stay in strhw_limb_adder512.

Test Plan:
- Reset release, then a=0, b=0 pulse -> ready_o rises exactly 8 edges after trg capture; result_o=0; state_o CLEAR->BUSY->DONE.
- a=0, b=512 (N update) -> result_o=512'h200. Then a=512'h200, b=512 -> 512'h400, issued as back-to-back ops with trg on the edge after DONE.
- a=64'hFFFF_FFFF_FFFF_FFFF (limb 0 all ones), b=1 -> result_o=512'h1_0000_0000_0000_0000, i.e. carry crosses a limb boundary.
- a=2^512-1, b=1 -> result_o=0 with ready_o=1 (full carry ripple, wrap discarded). Repeat with a=b=2^512-1 -> 2^512-2.
- trg_i pulsed at cycles 3 and 5 of BUSY with different a_i/b_i -> ignored; original sum delivered at edge 8; ready_o low the whole time.
- rst_ni asserted asynchronously mid-BUSY (between edges) -> outputs cleared immediately to 0/0/CLEAR. A new op after release gives the correct sum (random pair checked against a reference model). Also run 1000 random pairs with LIMB_W=32 and 128.
